// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the pipeline control blocks: opcodes,
// instruction field positions and the interlock FSM state encoding.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Low bit positions of the 5-bit register fields
    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters. Each of x1..x31 has a saturating
// up/down counter; x0 is permanently zero. Lookup outputs report whether a
// source register has a write pending and whether a destination is full.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_incEn,
    input  logic [REG_W-1:0] i_incAddr,
    input  logic             i_decEn,
    input  logic [REG_W-1:0] i_decAddr,
    input  logic [REG_W-1:0] i_rs1Addr,
    input  logic [REG_W-1:0] i_rs2Addr,
    input  logic [REG_W-1:0] i_rdAddr,
    output logic             o_rs1Busy,
    output logic             o_rs2Busy,
    output logic             o_rdFull,
    output logic [1:0]       o_busyCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt     [32];
    logic [CNT_W-1:0] w_cntNext [32];
    logic [31:0]      w_inc;
    logic [31:0]      w_dec;
    logic [5:0]       w_nonZero;

    // Select which counters see an increment (issue) or decrement (writeback);
    // a writeback to an idle register is dropped so counts never underflow
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < 32; i++) begin
            w_inc[i] = i_incEn && (i_incAddr == REG_W'(i));
            w_dec[i] = i_decEn && (i_decAddr == REG_W'(i)) && (r_cnt[i] != '0);
        end
    end

    // Next count: simultaneous issue and writeback cancel out
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_cntNext[i] = r_cnt[i];
        end
        w_cntNext[0] = '0;
        for (int i = 1; i < 32; i++) begin
            if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CNT_MAX)) begin
                w_cntNext[i] = r_cnt[i] + CNT_W'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
                w_cntNext[i] = r_cnt[i] - CNT_W'(1);
            end
        end
    end

    // Counter storage with synchronous clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    // Count registers with writes outstanding for the debug output
    always_comb begin
        w_nonZero = '0;
        for (int i = 1; i < 32; i++) begin
            w_nonZero = w_nonZero + {5'd0, (r_cnt[i] != '0)};
        end
    end

    assign o_rs1Busy = (r_cnt[i_rs1Addr] != '0);
    assign o_rs2Busy = (r_cnt[i_rs2Addr] != '0);
    assign o_rdFull  = (r_cnt[i_rdAddr] == CNT_MAX);
    assign o_busyCnt = (w_nonZero >= 6'd3) ? 2'd3 : w_nonZero[1:0];

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and flush controller between fetch and decode: stalls fetch on
// read-after-write hazards against in-flight writes and kills wrong-path
// slots for a fixed number of cycles after an execute-stage redirect.
module hazard_ctrl
    import rv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic        exe_redirect,
    output logic        hold_id,
    output logic        stall_if,
    output logic        kill_if,
    output logic        issue,
    output logic [1:0]  busy_cnt
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [FLUSH_W-1:0] r_flushCnt;
    logic [FLUSH_W-1:0] w_nextFlushCnt;

    logic [6:0]       w_opcode;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic             w_writesRd;
    logic             w_writesRdNz;
    logic             w_usesRs1;
    logic             w_usesRs2;
    logic             w_rs1Busy;
    logic             w_rs2Busy;
    logic             w_rdFull;
    logic             w_hazard;
    logic             w_issue;
    logic [1:0]       w_busyCnt;
    logic             w_unused;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[RD_LSB  +: REG_W];
    assign w_rs1    = if_instr[RS1_LSB +: REG_W];
    assign w_rs2    = if_instr[RS2_LSB +: REG_W];

    // funct3/funct7 never influence register usage, so they are dropped here
    assign w_unused = ^{if_instr[31:25], if_instr[14:12]};

    // Classify the fetched instruction's register reads and write; unknown
    // opcodes touch no registers and flow through as a NOP
    always_comb begin
        w_writesRd = 1'b0;
        w_usesRs1  = 1'b0;
        w_usesRs2  = 1'b0;
        case (w_opcode)
            OP_LOAD:   begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; end
            OP_STORE:  begin w_usesRs1  = 1'b1; w_usesRs2 = 1'b1; end
            OP_LUI:    begin w_writesRd = 1'b1; end
            OP_AUIPC:  begin w_writesRd = 1'b1; end
            OP_R:      begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; w_usesRs2 = 1'b1; end
            OP_I:      begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; end
            OP_BRANCH: begin w_usesRs1  = 1'b1; w_usesRs2 = 1'b1; end
            OP_JAL:    begin w_writesRd = 1'b1; end
            OP_JALR:   begin w_writesRd = 1'b1; w_usesRs1 = 1'b1; end
            default:   begin w_writesRd = 1'b0; end
        endcase
    end

    assign w_writesRdNz = w_writesRd && (w_rd != '0);

    reg_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_incEn   (w_issue && w_writesRdNz),
        .i_incAddr (w_rd),
        .i_decEn   (wb_en),
        .i_decAddr (wb_addr),
        .i_rs1Addr (w_rs1),
        .i_rs2Addr (w_rs2),
        .i_rdAddr  (w_rd),
        .o_rs1Busy (w_rs1Busy),
        .o_rs2Busy (w_rs2Busy),
        .o_rdFull  (w_rdFull),
        .o_busyCnt (w_busyCnt)
    );

    // Hazard only looks at registered counts; a same-cycle writeback still stalls
    assign w_hazard = if_valid &&
                      ((w_usesRs1 && (w_rs1 != '0) && w_rs1Busy) ||
                       (w_usesRs2 && (w_rs2 != '0) && w_rs2Busy) ||
                       (w_writesRdNz && w_rdFull));

    // FSM state and flush countdown register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_flushCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_flushCnt <= w_nextFlushCnt;
        end
    end

    // A redirect (re)arms the flush window from any state; the window ends
    // once the countdown has reached its last slot
    always_comb begin
        w_nextState    = r_state;
        w_nextFlushCnt = r_flushCnt;
        if (exe_redirect) begin
            w_nextState    = FLUSH;
            w_nextFlushCnt = FLUSH_W'(FLUSH_CYCLES);
        end else if (r_state == FLUSH) begin
            if (r_flushCnt <= FLUSH_W'(1)) begin
                w_nextState    = RUN;
                w_nextFlushCnt = '0;
            end else begin
                w_nextFlushCnt = r_flushCnt - FLUSH_W'(1);
            end
        end
    end

    // Drive decode/fetch controls; reset and redirect override the hazard stall
    always_comb begin
        w_issue  = 1'b0;
        hold_id  = 1'b1;
        stall_if = 1'b0;
        kill_if  = 1'b0;
        if (rst) begin
            hold_id = 1'b1;
        end else if (exe_redirect) begin
            kill_if = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    w_issue  = if_valid && !w_hazard;
                    hold_id  = !w_issue;
                    stall_if = w_hazard;
                end
                FLUSH: begin
                    kill_if = 1'b1;
                end
                default: begin
                    hold_id = 1'b1;
                end
            endcase
        end
    end

    assign issue    = w_issue;
    assign busy_cnt = rst ? 2'd0 : w_busyCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a register-count / flush-window model
// is checked against the DUT every cycle, and directed sequences carry
// hand-computed expectations for key cycles.
module tb_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_MAX      = 3;

    localparam logic [31:0] ADDI_X1  = 32'h00500093;
    localparam logic [31:0] LW_X5    = 32'h00012283;
    localparam logic [31:0] ADD_X6   = 32'h00728333;
    localparam logic [31:0] ADDI_X3  = 32'h00100193;
    localparam logic [31:0] ADDI_X0  = 32'h00000013;
    localparam logic [31:0] ADD_X0   = 32'h00000033;
    localparam logic [31:0] BAD_OP   = 32'hFFFFFFFF;
    localparam logic [31:0] ADDI_X10 = 32'h00000513;
    localparam logic [31:0] ADDI_X11 = 32'h00000593;
    localparam logic [31:0] ADDI_X12 = 32'h00000613;
    localparam logic [31:0] ADDI_X13 = 32'h00000693;

    logic        clk;
    logic        rst;
    logic        ifValid;
    logic [31:0] ifInstr;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic        exeRedirect;
    logic        holdId;
    logic        stallIf;
    logic        killIf;
    logic        issueOut;
    logic [1:0]  busyCnt;

    int nCompared   = 0;
    int nMismatched = 0;

    int mCnt [32];
    int mFlushLeft = 0;

    hazard_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (ifValid),
        .if_instr     (ifInstr),
        .wb_en        (wbEn),
        .wb_addr      (wbAddr),
        .exe_redirect (exeRedirect),
        .hold_id      (holdId),
        .stall_if     (stallIf),
        .kill_if      (killIf),
        .issue        (issueOut),
        .busy_cnt     (busyCnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareVal(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void decodeInstr(input logic [31:0] ins, output bit wr,
                                        output bit u1, output bit u2);
        wr = 0; u1 = 0; u2 = 0;
        case (ins[6:0])
            7'b0000011: begin wr = 1; u1 = 1; end
            7'b0100011: begin u1 = 1; u2 = 1; end
            7'b0110111: wr = 1;
            7'b0010111: wr = 1;
            7'b0110011: begin wr = 1; u1 = 1; u2 = 1; end
            7'b0010011: begin wr = 1; u1 = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; end
            7'b1101111: wr = 1;
            7'b1100111: begin wr = 1; u1 = 1; end
            default: ;
        endcase
    endfunction

    function automatic bit modelHazard();
        bit wr, u1, u2;
        int rd, rs1, rs2;
        decodeInstr(ifInstr, wr, u1, u2);
        rd  = int'(ifInstr[11:7]);
        rs1 = int'(ifInstr[19:15]);
        rs2 = int'(ifInstr[24:20]);
        return ifValid && ((u1 && rs1 != 0 && mCnt[rs1] != 0) ||
                           (u2 && rs2 != 0 && mCnt[rs2] != 0) ||
                           (wr && rd != 0 && mCnt[rd] >= CNT_MAX));
    endfunction

    function automatic void modelOutputs(output bit eIssue, output bit eHold,
                                         output bit eStall, output bit eKill,
                                         output int eBusy);
        bit hz;
        int nz;
        eIssue = 0; eHold = 1; eStall = 0; eKill = 0; eBusy = 0;
        if (rst) return;
        nz = 0;
        for (int r = 1; r < 32; r++) if (mCnt[r] != 0) nz++;
        eBusy = (nz > 3) ? 3 : nz;
        if (exeRedirect || mFlushLeft > 0) begin
            eKill = 1;
        end else begin
            hz     = modelHazard();
            eStall = hz;
            eIssue = ifValid && !hz;
            eHold  = !eIssue;
        end
    endfunction

    // Advance the model on each edge using the inputs the DUT samples
    always @(posedge clk) begin
        bit eIssue, eHold, eStall, eKill, wr, u1, u2;
        int eBusy, rd, wa;
        bit inc, dec;
        if (rst) begin
            for (int r = 0; r < 32; r++) mCnt[r] = 0;
            mFlushLeft = 0;
        end else begin
            modelOutputs(eIssue, eHold, eStall, eKill, eBusy);
            decodeInstr(ifInstr, wr, u1, u2);
            rd = int'(ifInstr[11:7]);
            wa = int'(wbAddr);
            for (int r = 1; r < 32; r++) begin
                inc = eIssue && wr && rd == r;
                dec = wbEn && wa == r && mCnt[r] > 0;
                if (inc && !dec && mCnt[r] < CNT_MAX) mCnt[r] = mCnt[r] + 1;
                else if (dec && !inc) mCnt[r] = mCnt[r] - 1;
            end
            if (exeRedirect) mFlushLeft = FLUSH_CYCLES;
            else if (mFlushLeft > 0) mFlushLeft = mFlushLeft - 1;
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        bit eIssue, eHold, eStall, eKill;
        int eBusy;
        modelOutputs(eIssue, eHold, eStall, eKill, eBusy);
        compareVal("cyc_issue",    int'(issueOut), int'(eIssue));
        compareVal("cyc_hold_id",  int'(holdId),   int'(eHold));
        compareVal("cyc_stall_if", int'(stallIf),  int'(eStall));
        compareVal("cyc_kill_if",  int'(killIf),   int'(eKill));
        compareVal("cyc_busy_cnt", int'(busyCnt),  eBusy);
    end

    task automatic applyStimulus(input bit r, input bit v, input logic [31:0] ins,
                                 input bit we, input logic [4:0] wa, input bit redir);
        @(posedge clk);
        #1;
        rst         = r;
        ifValid     = v;
        ifInstr     = ins;
        wbEn        = we;
        wbAddr      = wa;
        exeRedirect = redir;
    endtask

    task automatic checkOutput(input string name, input bit eIssue, input bit eHold,
                               input bit eStall, input bit eKill, input int eBusy);
        @(negedge clk);
        compareVal({name, "_issue"}, int'(issueOut), int'(eIssue));
        compareVal({name, "_hold"},  int'(holdId),   int'(eHold));
        compareVal({name, "_stall"}, int'(stallIf),  int'(eStall));
        compareVal({name, "_kill"},  int'(killIf),   int'(eKill));
        compareVal({name, "_busy"},  int'(busyCnt),  eBusy);
    endtask

    task automatic checkCnt(input string name, input int r, input int exp);
        compareVal(name, mCnt[r], exp);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 32'h0, 0, 5'd0, 0);
    endtask

    // Directed sequences
    initial begin
        rst = 1'b1; ifValid = 1'b0; ifInstr = '0;
        wbEn = 1'b0; wbAddr = '0; exeRedirect = 1'b0;

        // Reset and a single producer
        applyStimulus(1, 1, ADDI_X1, 0, 5'd0, 0); checkOutput("rst", 0, 1, 0, 0, 0);
        applyStimulus(1, 1, ADDI_X1, 0, 5'd0, 0);
        applyStimulus(0, 1, ADDI_X1, 0, 5'd0, 0); checkOutput("addi", 1, 0, 0, 0, 0);
        idle();                                   checkOutput("addi_cnt", 0, 1, 0, 0, 1);
        checkCnt("x1_cnt_one", 1, 1);
        applyStimulus(0, 0, 32'h0, 1, 5'd1, 0);   checkOutput("wb_x1", 0, 1, 0, 0, 1);
        idle();                                   checkOutput("x1_clear", 0, 1, 0, 0, 0);
        checkCnt("x1_cnt_zero", 1, 0);

        // Load-use: two stall cycles
        applyStimulus(0, 1, LW_X5, 0, 5'd0, 0);   checkOutput("lw", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, ADD_X6, 0, 5'd0, 0);  checkOutput("lu_stall1", 0, 1, 1, 0, 1);
        applyStimulus(0, 1, ADD_X6, 1, 5'd5, 0);  checkOutput("lu_stall2", 0, 1, 1, 0, 1);
        applyStimulus(0, 1, ADD_X6, 0, 5'd0, 0);  checkOutput("lu_issue", 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h0, 1, 5'd6, 0);   checkOutput("x6_busy", 0, 1, 0, 0, 1);
        idle();                                   checkOutput("x6_clear", 0, 1, 0, 0, 0);

        // Redirect and flush window
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 1); checkOutput("redir", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("flush1", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("flush2", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("flush_done", 1, 0, 0, 0, 0);

        // Redirect mid-flush restarts the window
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 1); checkOutput("redir_a", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("redir_a1", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 1); checkOutput("restart", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("restart1", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("restart2", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("restart_done", 1, 0, 0, 0, 0);

        // Counter full on x3
        applyStimulus(0, 1, ADDI_X3, 0, 5'd0, 0); checkOutput("x3_w1", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, ADDI_X3, 0, 5'd0, 0); checkOutput("x3_w2", 1, 0, 0, 0, 1);
        applyStimulus(0, 1, ADDI_X3, 0, 5'd0, 0); checkOutput("x3_w3", 1, 0, 0, 0, 1);
        applyStimulus(0, 1, ADDI_X3, 0, 5'd0, 0); checkOutput("x3_full", 0, 1, 1, 0, 1);
        checkCnt("x3_cnt_max", 3, 3);
        applyStimulus(0, 1, ADDI_X3, 1, 5'd3, 0); checkOutput("x3_full_wb", 0, 1, 1, 0, 1);
        applyStimulus(0, 1, ADDI_X3, 1, 5'd3, 0); checkOutput("x3_inc_dec", 1, 0, 0, 0, 1);
        idle();                                   checkOutput("x3_after", 0, 1, 0, 0, 1);
        checkCnt("x3_cnt_same", 3, 2);
        applyStimulus(0, 0, 32'h0, 1, 5'd3, 0);
        applyStimulus(0, 0, 32'h0, 1, 5'd3, 0);
        idle();                                   checkOutput("x3_drained", 0, 1, 0, 0, 0);
        checkCnt("x3_cnt_zero", 3, 0);

        // x0 producers/consumers, idle writeback, unknown opcode
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("x0_prod", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, ADD_X0, 0, 5'd0, 0);  checkOutput("x0_cons", 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h0, 1, 5'd9, 0);   checkOutput("wb_x9_idle", 0, 1, 0, 0, 0);
        idle();                                   checkOutput("x9_after", 0, 1, 0, 0, 0);
        checkCnt("x9_cnt_zero", 9, 0);
        applyStimulus(0, 1, BAD_OP, 0, 5'd0, 0);  checkOutput("bad_op", 1, 0, 0, 0, 0);
        idle();                                   checkOutput("bad_op_after", 0, 1, 0, 0, 0);

        // busy_cnt saturation
        applyStimulus(0, 1, ADDI_X10, 0, 5'd0, 0); checkOutput("sat0", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, ADDI_X11, 0, 5'd0, 0); checkOutput("sat1", 1, 0, 0, 0, 1);
        applyStimulus(0, 1, ADDI_X12, 0, 5'd0, 0); checkOutput("sat2", 1, 0, 0, 0, 2);
        applyStimulus(0, 1, ADDI_X13, 0, 5'd0, 0); checkOutput("sat3", 1, 0, 0, 0, 3);
        idle();                                    checkOutput("sat4", 0, 1, 0, 0, 3);

        // Reset during a load-use stall
        applyStimulus(0, 1, LW_X5, 0, 5'd0, 0);   checkOutput("lw2", 1, 0, 0, 0, 3);
        applyStimulus(0, 1, ADD_X6, 0, 5'd0, 0);  checkOutput("lu2_stall", 0, 1, 1, 0, 3);
        applyStimulus(1, 1, ADD_X6, 0, 5'd0, 0);  checkOutput("rst_stall", 0, 1, 0, 0, 0);
        applyStimulus(0, 1, ADD_X6, 0, 5'd0, 0);  checkOutput("rst_stall_issue", 1, 0, 0, 0, 0);
        checkCnt("x5_cnt_cleared", 5, 0);
        applyStimulus(0, 0, 32'h0, 1, 5'd6, 0);
        idle();

        // Reset during a flush
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 1); checkOutput("redir_b", 0, 1, 0, 1, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("redir_b1", 0, 1, 0, 1, 0);
        applyStimulus(1, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("rst_flush", 0, 1, 0, 0, 0);
        applyStimulus(0, 1, ADDI_X0, 0, 5'd0, 0); checkOutput("rst_flush_issue", 1, 0, 0, 0, 0);

        idle();
        idle();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
